secuenciador_mac: RTL and testbench

- Sequential FIR/MAC controller that drives the shared arithmetic stage and consumes its result. Per sample it iterates TAPS times.
- Each iteration presents coefficient, delayed sample and running sum on Constantes_G / Multip_G / Entrada_G, then captures the 2N-bit Valores.
- The captured value is rescaled and saturated back to N bits and fed back as the next Entrada_G.
- Sits between the sample source (upstream) and the output register/DAC path (downstream).

---
 rtl/secuenciador_mac.sv | 179 +++++++++++++++++
 tb/tb_secuenciador_mac.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_mac.sv
// -----------------------------------------------------------------------------
// secuenciador_mac
//
// Sequential FIR / multiply-accumulate controller. For every accepted sample
// it walks TAPS coefficients. Each step it presents one coefficient, one
// delayed sample and the running sum to a shared external arithmetic stage.
// It then takes that stage's 2N-bit result, rescales it back to Q(N-F).F and
// saturates it to N bits. The saturated value becomes the next running sum.
// After the last tap, that value is the filter output.
//
// Optional build macro:
//   SECUENCIADOR_ROUND_EN  - rescale rounds half-up instead of truncating
//                            toward minus infinity.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         one-cycle request; x_in holds a new sample
//   x_in          new signed sample (N bits)
//   coef_in       packed coefficients, coefficient i at [i*N +: N]
//   Constantes_G  coefficient to the arithmetic stage
//   Multip_G      delayed sample to the arithmetic stage
//   Entrada_G     running sum to the arithmetic stage
//   Valores       combinational 2N-bit result from the arithmetic stage
//   y_out         registered filter result
//   done          one-cycle pulse when y_out updates
//   busy          high while an operation is in flight (MAC and FIN)
//   sat           high if any step of the last operation saturated
//
// Handshake: start is a single-cycle request. It is only accepted in IDLE,
// which is when busy is low. A start seen while busy is dropped and is not
// queued. The matching completion is a single-cycle done pulse. Valores must
// be valid in the same cycle that Constantes_G, Multip_G and Entrada_G are
// presented.
//
// The FSM state is held in the register `state` (IDLE/MAC/FIN) so that
// checkers can bind to it.
// -----------------------------------------------------------------------------
module secuenciador_mac #(
  parameter int N    = 25,
  parameter int F    = 10,
  parameter int TAPS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N-1:0]        x_in,
  input  logic [TAPS*N-1:0]   coef_in,
  output logic [N-1:0]        Constantes_G,
  output logic [N-1:0]        Multip_G,
  output logic [N-1:0]        Entrada_G,
  input  logic [2*N-1:0]      Valores,
  output logic [N-1:0]        y_out,
  output logic                done,
  output logic                busy,
  output logic                sat
);

  localparam int IW = $clog2(TAPS);

  // Saturation bounds, sign-extended to the 2N+1-bit rescale width.
  localparam logic signed [2*N:0] MAX_V = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] MIN_V = {{(N+2){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [N-1:0]    d [TAPS];
  logic [N-1:0]    acc;
  logic [IW-1:0]   idx;
  logic            sat_int;

  logic            last_step;
  logic [N-1:0]    coef_sel;
  logic signed [2*N:0] val_ext;
  logic signed [2*N:0] val_adj;
  logic signed [2*N:0] r_shift;
  logic [N-1:0]    res;
  logic            step_sat;

  assign last_step = (idx == IW'(TAPS - 1));
  assign coef_sel  = coef_in[int'(idx)*N +: N];

  // One extra bit of headroom so that adding the rounding constant can never
  // wrap the 2N-bit result.
  assign val_ext = $signed({Valores[2*N-1], Valores});

`ifdef SECUENCIADOR_ROUND_EN
  localparam logic signed [2*N:0] RND = (2*N+1)'(1) <<< (F - 1);
  assign val_adj = val_ext + RND;
`else
  assign val_adj = val_ext;
`endif

  assign r_shift = val_adj >>> F;

  // Clamp the rescaled step result to the N-bit signed range.
  always_comb begin
    res      = r_shift[N-1:0];
    step_sat = 1'b0;
    if (r_shift > MAX_V) begin
      res      = MAX_V[N-1:0];
      step_sat = 1'b1;
    end else if (r_shift < MIN_V) begin
      res      = MIN_V[N-1:0];
      step_sat = 1'b1;
    end
  end

  // Next-state logic and the arithmetic-stage operand outputs.
  always_comb begin
    state_nxt    = state;
    Constantes_G = '0;
    Multip_G     = '0;
    Entrada_G    = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = MAC;
      end
      MAC: begin
        Constantes_G = coef_sel;
        Multip_G     = d[idx];
        Entrada_G    = acc;
        if (last_step) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      idx     <= '0;
      sat_int <= 1'b0;
      y_out   <= '0;
      done    <= 1'b0;
      sat     <= 1'b0;
      for (int i = 0; i < TAPS; i++) d[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d[0] <= x_in;
            for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
            acc     <= '0;
            idx     <= '0;
            sat_int <= 1'b0;
          end
        end
        MAC: begin
          acc <= res;
          idx <= idx + 1'b1;
          if (step_sat) sat_int <= 1'b1;
          if (last_step) begin
            y_out <= res;
            sat   <= sat_int | step_sat;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_mac.sv
module tb_secuenciador_mac;

  localparam int N    = 25;
  localparam int F    = 10;
  localparam int TAPS = 3;

`ifdef SECUENCIADOR_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      start = 1'b0;
  logic signed [N-1:0]       x_in = '0;
  logic [TAPS*N-1:0]         coef_in = '0;
  logic signed [N-1:0]       Constantes_G;
  logic signed [N-1:0]       Multip_G;
  logic signed [N-1:0]       Entrada_G;
  logic signed [2*N-1:0]     Valores;
  logic signed [N-1:0]       y_out;
  logic                      done;
  logic                      busy;
  logic                      sat;

  secuenciador_mac #(.N(N), .F(F), .TAPS(TAPS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .x_in         (x_in),
    .coef_in      (coef_in),
    .Constantes_G (Constantes_G),
    .Multip_G     (Multip_G),
    .Entrada_G    (Entrada_G),
    .Valores      (Valores),
    .y_out        (y_out),
    .done         (done),
    .busy         (busy),
    .sat          (sat)
  );

  // Model of the shared arithmetic stage: coef*sample + (sum << F).
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] ent_sh;
  always_comb begin
    prod    = Constantes_G * Multip_G;
    ent_sh  = $signed({{N{Entrada_G[N-1]}}, Entrada_G}) <<< F;
    Valores = prod + ent_sh;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [N:0] exp_q[$];   // {sat, y_out}

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    logic [N:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'sd1, 64'sd0);
      end else begin
        e = exp_q.pop_front();
        chk("y_out", y_out, $signed(e[N-1:0]));
        chk("sat", {63'd0, sat}, {63'd0, e[N]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_coef(input logic signed [N-1:0] c0,
                          input logic signed [N-1:0] c1,
                          input logic signed [N-1:0] c2);
    coef_in = {c2, c1, c0};
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic signed [N-1:0] x,
                       input logic signed [N-1:0] ey, input logic es);
    exp_q.push_back({es, ey});
    @(negedge clk);
    x_in  = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait until every expected result has been consumed.
  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int done_at;
    int busy_cnt;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_y_out", y_out, 0);
    chk("rst_done", {63'd0, done}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_sat", {63'd0, sat}, 0);
    chk("rst_coef_g", Constantes_G, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity with latency / busy-width measurement.
    set_coef(25'sd1024, 25'sd0, 25'sd0);
    exp_q.push_back({1'b0, 25'sd5120});
    @(negedge clk);
    x_in  = 25'sd5120;
    start = 1'b1;
    done_at  = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = n;
    end
    chk("latency_done", done_at, TAPS + 1);
    chk("busy_cycles", busy_cnt, TAPS + 1);
    drain();

    // Averaging with 0.5 coefficients.
    do_reset();
    set_coef(25'sd512, 25'sd512, 25'sd512);
    issue(25'sd1024, 25'sd512, 1'b0);  drain();
    issue(25'sd2048, 25'sd1536, 1'b0); drain();
    issue(25'sd3072, 25'sd3072, 1'b0); drain();

    // Saturation, both directions, then a benign sample clears sat.
    do_reset();
    set_coef(25'sd16777215, 25'sd0, 25'sd0);
    issue(25'sd16777215, 25'sd16777215, 1'b1); drain();
    set_coef(-25'sd1024, 25'sd0, 25'sd0);
    issue(-25'sd16777216, 25'sd16777215, 1'b1); drain();
    set_coef(25'sd1024, 25'sd0, 25'sd0);
    issue(25'sd100, 25'sd100, 1'b0); drain();

    // Rescale: truncation vs round-half-up.
    set_coef(25'sd1, 25'sd0, 25'sd0);
    issue(25'sd512, ROUND ? 25'sd1 : 25'sd0, 1'b0); drain();
    issue(25'sd511, 25'sd0, 1'b0); drain();
    issue(-25'sd1, ROUND ? 25'sd0 : -25'sd1, 1'b0); drain();

    // Start while busy is ignored: one done, delay line shifted once.
    do_reset();
    set_coef(25'sd1024, 25'sd1024, 25'sd0);
    exp_q.push_back({1'b0, 25'sd1000});
    @(negedge clk);
    x_in  = 25'sd1000;
    start = 1'b1;
    @(negedge clk);
    x_in  = 25'sd2000;
    @(negedge clk);
    start = 1'b0;
    drain();
    issue(25'sd3000, 25'sd4000, 1'b0); drain();

    // Asynchronous reset during MAC idx=1 aborts with no done.
    set_coef(25'sd1024, 25'sd1024, 25'sd1024);
    @(negedge clk);
    x_in  = 25'sd777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y_out", y_out, 0);
    chk("arst_done", {63'd0, done}, 0);
    chk("arst_busy", {63'd0, busy}, 0);
    chk("arst_sat", {63'd0, sat}, 0);
    chk("arst_coef_g", Constantes_G, 0);
    chk("arst_mult_g", Multip_G, 0);
    chk("arst_entr_g", Entrada_G, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_coef(25'sd0, 25'sd1024, 25'sd0);
    issue(25'sd1024, 25'sd0, 1'b0); drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
